echo_indication_arbiter: RTL
============================

// Module: echo_indication_arbiter
// PURPOSE
//  Shares one EchoIndication echo() channel among NREQ echo-response FIFOs.
//  Round-robin picks a requester whose FIFO has data, pops it (deq/first) and holds the word
//  in a one-entry output register until the indication side accepts it. Sits between
//  the per-client Fifo1 instances and the single indication proxy; replaces a per-client rule_respond.
// PARAMETERS
//  NREQ    4   number of requesting FIFOs (2..16)
//  DWIDTH  32  echo payload width
//  TAGW    $clog2(NREQ) (localparam) source-index width
// PORTS
//  CLK              in   1            clock, all state on rising edge
//  RST              in   1            reset, asynchronous, active-high
//  req_first__RDY   in   NREQ         bit i: FIFO i non-empty (first__RDY & deq__RDY)
//  req_first        in   NREQ*DWIDTH  FIFO i head word at bits [i*DWIDTH +: DWIDTH]
//  req_deq__ENA     out  NREQ         one-hot pop strobe to FIFO i (combinational)
//  ind_echo__RDY    in   1            indication side can accept this cycle
//  ind_echo__ENA    out  1            word transferred this cycle
//  ind_echo_v       out  DWIDTH       payload
//  ind_echo_tag     out  TAGW         index of source FIFO
//  xfer_count       out  32           completed indication transfers, wraps 2^32-1 -> 0
// BEHAVIOUR
//  State: out_valid, out_data, out_tag, last_grant (TAGW), xfer_count.
//  Reset (async, RST=1): out_valid=0, out_data=0, out_tag=0, last_grant=NREQ-1, xfer_count=0;
//   outputs: req_deq__ENA=0, ind_echo__ENA=0, ind_echo_v=0, ind_echo_tag=0.
//  FSM, 2 states encoded by out_valid: EMPTY (0), HOLD (1).
//  ind_echo__ENA = out_valid & ind_echo__RDY; ind_echo_v/tag = out_data/out_tag.
//  can_load = !out_valid | ind_echo__ENA (a pass-through slot exists for back-to-back transfers).
//  Grant: when can_load & |req_first__RDY, pick the first set bit scanning
//   last_grant+1, last_grant+2, ... modulo NREQ (wraps NREQ-1 -> 0). req_deq__ENA = onehot(g).
//   No grant -> req_deq__ENA = 0. Never more than one bit set.
//  On grant edge: out_data <= req_first[g], out_tag <= g, out_valid <= 1, last_grant <= g.
//  ind_echo__ENA without grant: out_valid <= 0 (HOLD -> EMPTY).
//  ind_echo__ENA with grant: out_valid stays 1, new word loaded. Sustains 1 word/cycle.
//  HOLD & !ind_echo__RDY: no grant, and out_data/out_tag are held stable.
//  xfer_count increments on each ind_echo__ENA.
//  Latency: request first seen in cycle t (slot free) -> pop in t -> ind_echo__ENA earliest t+1.
//  Fairness: a requester that keeps RDY high is granted within NREQ grants.
//  Requests are not latched. A requester dropping RDY before its grant loses no data.
//  RST mid-HOLD discards the buffered word. The arbiter never pops FIFOs while RST=1.
// TESTING
//  1 reset: RST pulsed mid-cycle -> all outputs 0 immediately, last_grant=NREQ-1, count 0.
//  2 single: only FIFO2 RDY, data 0xCAFE0002, ind RDY=1 -> deq__ENA=4'b0100 at t,
//    ind_echo__ENA at t+1 with v=0xCAFE0002, tag=2; xfer_count=1.
//  3 round-robin: all 4 RDY continuously, ind RDY=1 -> tags 0,1,2,3,0,1 on consecutive cycles,
//    one pop per cycle.
//  4 backpressure: word held, ind RDY=0 for 5 cycles -> v/tag stable, req_deq__ENA=0;
//    RDY rises -> transfer that cycle plus next grant the same cycle.
//  5 wrap/skip: last_grant=3, only FIFO1 RDY -> grant 1; then FIFO0 and FIFO1 RDY -> grant 0 after 1? no: grant 0.
//  6 counter wrap: preload xfer_count to 32'hFFFFFFFF via force, one transfer -> 0.

Source files
------------

// File: rtl/echo_indication_arbiter.sv
// Round-robin arbiter that drains NREQ echo FIFOs into a single echo indication channel.
// One-entry output register; a new word can load in the same cycle the held word is accepted.
module echo_indication_arbiter #(
  parameter  int NREQ   = 4,
  parameter  int DWIDTH = 32,
  localparam int TAGW   = $clog2(NREQ)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        req_first__RDY,
  input  logic [NREQ*DWIDTH-1:0] req_first,
  output logic [NREQ-1:0]        req_deq__ENA,
  input  logic                   ind_echo__RDY,
  output logic                   ind_echo__ENA,
  output logic [DWIDTH-1:0]      ind_echo_v,
  output logic [TAGW-1:0]        ind_echo_tag,
  output logic [31:0]            xfer_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [TAGW-1:0]   last_q, last_d;
  logic [31:0]       cnt_q;
  logic [31:0]       cnt_d;
  logic [TAGW-1:0]   gnt_idx;
  logic              gnt_found;
  logic              gnt_vld;
  logic              can_load;

  // Scan starting just after the previous winner so every requester is served in turn.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!gnt_found && req_first__RDY[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = TAGW'(idx);
      end
    end
  end

  assign ind_echo__ENA = (state_q == HOLD) & ind_echo__RDY;
  assign can_load      = (state_q == EMPTY) | ind_echo__ENA;
  assign gnt_vld       = can_load & gnt_found & ~RST;
  assign req_deq__ENA  = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
  assign cnt_d         = cnt_q + 32'(ind_echo__ENA);

  assign ind_echo_v    = data_q;
  assign ind_echo_tag  = tag_q;
  assign xfer_count    = cnt_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tag_d   = tag_q;
    last_d  = last_q;
    case (state_q)
      EMPTY: begin
        if (gnt_vld) begin
          state_d = HOLD;
          data_d  = req_first[int'(gnt_idx)*DWIDTH +: DWIDTH];
          tag_d   = gnt_idx;
          last_d  = gnt_idx;
        end
      end
      HOLD: begin
        if (gnt_vld) begin
          data_d = req_first[int'(gnt_idx)*DWIDTH +: DWIDTH];
          tag_d  = gnt_idx;
          last_d = gnt_idx;
        end else if (ind_echo__ENA) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
      data_q  <= '0;
      tag_q   <= '0;
      last_q  <= TAGW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
